// File: rtl/synth_seq_pkg.sv
// Shared types and constants for the step sequencer.
package synth_seq_pkg;

  // Sequencer play state.
  typedef enum logic {
    STOPPED = 1'b0,
    PLAY    = 1'b1
  } seq_state_t;

  // Tone code width shared with soundproc.
  localparam int SEQ_FREQ_BITS = 4;

  // One pattern entry: a rest flag and a tone code.
  typedef struct packed {
    logic                     rest;
    logic [SEQ_FREQ_BITS-1:0] freq;
  } step_t;

  // Shortest step length in clocks; smaller tempo_div values are clamped to this.
  localparam int MIN_DIV = 4;

endpackage

// File: rtl/tempo_counter.sv
// Step tick counter: counts 0..eff_div-1 while enabled and pulses tc on the last tick.
module tempo_counter #(
  parameter int TICK_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [TICK_BITS-1:0] eff_div,
  output logic [TICK_BITS-1:0] tick,
  output logic                 tc
);

  logic [TICK_BITS-1:0] tick_q, tick_d;

  // Terminal count uses >= so a mid-step shrink of eff_div ends the step on the next cycle.
  assign tc   = enable && (tick_q >= (eff_div - TICK_BITS'(1)));
  assign tick = tick_q;

  // Next-count selection: clear wins, then wrap on terminal count, else increment.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    tick_d = tick_q;
    if (clear) begin
      tick_d = '0;
    end else if (enable) begin
      tick_d = tc ? '0 : tick_q + TICK_BITS'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Programmable 8-step note sequencer feeding tone code and gate to soundproc.
module step_sequencer
  import synth_seq_pkg::*;
#(
  parameter int STEPS     = 8,
  parameter int FREQ_BITS = 4,
  parameter int TICK_BITS = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  input  logic [TICK_BITS-1:0]       tempo_div,
  input  logic [1:0]                 gate_len,
  input  logic                       wr_en,
  input  logic [$clog2(STEPS)-1:0]   wr_addr,
  input  logic [FREQ_BITS:0]         wr_data,
  output logic [FREQ_BITS-1:0]       tone_freq_bin,
  output logic                       hold,
  output logic [$clog2(STEPS)-1:0]   step_idx,
  output logic                       step_strobe
);

  localparam int IDX_W = $clog2(STEPS);

  seq_state_t           state_q, state_d;
  logic                 run_q;
  step_t                pattern_q [STEPS];
  step_t                pattern_d [STEPS];
  logic [FREQ_BITS-1:0] tone_q, tone_d;
  logic                 hold_q, hold_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 strobe_q, strobe_d;
  logic                 rest_q, rest_d;

  logic [TICK_BITS-1:0] eff_div;
  logic [TICK_BITS-1:0] q_div;
  logic [TICK_BITS-1:0] gate_lim;
  logic [TICK_BITS-1:0] tick;
  logic [TICK_BITS-1:0] tick_next;
  logic                 tc;
  logic                 cnt_en;
  logic                 cnt_clr;
  logic                 load;
  step_t                load_step;

  assign tone_freq_bin = tone_q;
  assign hold          = hold_q;
  assign step_idx      = idx_q;
  assign step_strobe   = strobe_q;

  // The counter only runs while playing; it is held at zero when stopped or stopping.
  assign cnt_en  = (state_q == PLAY);
  assign cnt_clr = (state_q != PLAY) || !run;

  tempo_counter #(
    .TICK_BITS (TICK_BITS)
  ) u_tempo_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (cnt_en),
    .clear   (cnt_clr),
    .eff_div (eff_div),
    .tick    (tick),
    .tc      (tc)
  );

  // Clamp the step length and derive the gate-off tick from the quarter-step size.
  always_comb begin
    eff_div  = (tempo_div < TICK_BITS'(MIN_DIV)) ? TICK_BITS'(MIN_DIV) : tempo_div;
    q_div    = eff_div >> 2;
    gate_lim = q_div * (TICK_BITS'(gate_len) + TICK_BITS'(1));
  end

  // Pattern write port; a load in the same cycle still reads the old entry from pattern_q.
  always_comb begin
    pattern_d = pattern_q;
    if (wr_en) begin
      pattern_d[wr_addr] = step_t'(wr_data);
    end
  end

  // Play FSM, step advance and registered-output precompute (outputs reflect the next tick).
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tone_d    = tone_q;
    rest_d    = rest_q;
    hold_d    = 1'b0;
    strobe_d  = 1'b0;
    load      = 1'b0;
    tick_next = '0;

    unique case (state_q)
      STOPPED: begin
        if (run && !run_q) begin
          state_d = PLAY;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      PLAY: begin
        if (!run) begin
          state_d = STOPPED;
          idx_d   = '0;
        end else if (tc) begin
          idx_d = idx_q + IDX_W'(1);
          load  = 1'b1;
        end else begin
          tick_next = tick + TICK_BITS'(1);
        end
      end
      default: state_d = STOPPED;
    endcase

    // A rest step keeps the previous tone and silences the gate for its whole duration.
    load_step = pattern_q[idx_d];
    if (load) begin
      strobe_d = 1'b1;
      rest_d   = load_step.rest;
      if (!load_step.rest) begin
        tone_d = load_step.freq;
      end
    end

    // Legato holds the gate through the step and into the next non-rest step.
    if (state_d == PLAY) begin
      hold_d = !rest_d && ((gate_len == 2'd3) || (tick_next < gate_lim));
    end
  end

  // State, output and pattern registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= STOPPED;
      run_q    <= 1'b0;
      tone_q   <= '0;
      hold_q   <= 1'b0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
      rest_q   <= 1'b1;
      // NOTE: the pattern store is deliberately reset to all rests, so it stays a flop array rather than a RAM.
      for (int i = 0; i < STEPS; i++) begin
        pattern_q[i] <= '{rest: 1'b1, freq: '0};
      end
    end else begin
      state_q   <= state_d;
      run_q     <= run;
      tone_q    <= tone_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      strobe_q  <= strobe_d;
      rest_q    <= rest_d;
      pattern_q <= pattern_d;
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer against a per-cycle behavioural model.
module tb_step_sequencer;

  localparam int STEPS     = 8;
  localparam int FREQ_BITS = 4;
  localparam int TICK_BITS = 24;
  localparam int IDX_W     = 3;

  logic                 clk;
  logic                 rst_n;
  logic                 run;
  logic [TICK_BITS-1:0] tempo_div;
  logic [1:0]           gate_len;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_addr;
  logic [FREQ_BITS:0]   wr_data;
  logic [FREQ_BITS-1:0] tone_freq_bin;
  logic                 hold;
  logic [IDX_W-1:0]     step_idx;
  logic                 step_strobe;

  int checks;
  int failures;

  // Model: pattern contents and the tone last presented to soundproc.
  logic [FREQ_BITS:0]   model_pat [STEPS];
  logic [FREQ_BITS-1:0] model_tone;

  step_sequencer #(
    .STEPS     (STEPS),
    .FREQ_BITS (FREQ_BITS),
    .TICK_BITS (TICK_BITS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .tempo_div     (tempo_div),
    .gate_len      (gate_len),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .tone_freq_bin (tone_freq_bin),
    .hold          (hold),
    .step_idx      (step_idx),
    .step_strobe   (step_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern write while stopped; model updated directly.
  task automatic write_step(input int addr, input bit rest, input int freq);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = IDX_W'(addr);
    wr_data = {rest, FREQ_BITS'(freq)};
    @(negedge clk);
    wr_en = 1'b0;
    model_pat[addr] = {rest, FREQ_BITS'(freq)};
  endtask

  // Raise run, check every cycle for `cycles` cycles against the model, then drop run and check the stop.
  task automatic play(input int tempo, input int gl, input int cycles, input bit rnd_wr, input string tag);
    int eff, q, tick, s, idx, paddr;
    bit pend;
    bit exp_hold;
    logic [FREQ_BITS:0] cur;
    logic [FREQ_BITS:0] pdata;
    eff  = (tempo < 4) ? 4 : tempo;
    q    = eff / 4;
    pend = 1'b0;
    cur  = '0;
    @(negedge clk);
    tempo_div = TICK_BITS'(tempo);
    gate_len  = 2'(gl);
    run       = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      tick = k % eff;
      s    = k / eff;
      idx  = s % STEPS;
      if (tick == 0) begin
        cur = model_pat[idx];
        if (!cur[FREQ_BITS]) model_tone = cur[FREQ_BITS-1:0];
      end
      exp_hold = !cur[FREQ_BITS] && ((gl == 3) || (tick < q * (gl + 1)));
      checks += 4;
      if (step_strobe !== (tick == 0)) begin
        failures++;
        $display("FAIL %s strobe k=%0d got=%0b exp=%0b", tag, k, step_strobe, (tick == 0));
      end
      if (step_idx !== IDX_W'(idx)) begin
        failures++;
        $display("FAIL %s step_idx k=%0d got=%0d exp=%0d", tag, k, step_idx, idx);
      end
      if (tone_freq_bin !== model_tone) begin
        failures++;
        $display("FAIL %s tone k=%0d got=%0d exp=%0d", tag, k, tone_freq_bin, model_tone);
      end
      if (hold !== exp_hold) begin
        failures++;
        $display("FAIL %s hold k=%0d got=%0b exp=%0b", tag, k, hold, exp_hold);
      end
      // A write issued last cycle landed on the same edge as any load just checked.
      if (pend) model_pat[paddr] = pdata;
      pend  = 1'b0;
      wr_en = 1'b0;
      if (rnd_wr && ($urandom_range(3) == 0 || tick == eff - 1)) begin
        paddr = (tick == eff - 1 || $urandom_range(1) == 1) ? (idx + 1) % STEPS : idx;
        pdata = FREQ_BITS'($urandom) | ((FREQ_BITS + 1)'($urandom_range(1)) << FREQ_BITS);
        wr_en   = 1'b1;
        wr_addr = IDX_W'(paddr);
        wr_data = pdata;
        pend    = 1'b1;
      end
    end
    run = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    if (pend) model_pat[paddr] = pdata;
    checks += 4;
    if (hold !== 1'b0) begin
      failures++;
      $display("FAIL %s stop_hold got=%0b exp=0", tag, hold);
    end
    if (step_idx !== '0) begin
      failures++;
      $display("FAIL %s stop_idx got=%0d exp=0", tag, step_idx);
    end
    if (step_strobe !== 1'b0) begin
      failures++;
      $display("FAIL %s stop_strobe got=%0b exp=0", tag, step_strobe);
    end
    if (tone_freq_bin !== model_tone) begin
      failures++;
      $display("FAIL %s stop_tone got=%0d exp=%0d", tag, tone_freq_bin, model_tone);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b0; tempo_div = '0; gate_len = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #1;
    checks += 4;
    if (tone_freq_bin !== '0) begin failures++; $display("FAIL reset tone got=%0d exp=0", tone_freq_bin); end
    if (hold !== 1'b0) begin failures++; $display("FAIL reset hold got=%0b exp=0", hold); end
    if (step_idx !== '0) begin failures++; $display("FAIL reset idx got=%0d exp=0", step_idx); end
    if (step_strobe !== 1'b0) begin failures++; $display("FAIL reset strobe got=%0b exp=0", step_strobe); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < STEPS; i++) model_pat[i] = {1'b1, FREQ_BITS'(0)};
    model_tone = '0;
    @(negedge clk);
    checks += 2;
    if (hold !== 1'b0) begin failures++; $display("FAIL idle hold got=%0b exp=0", hold); end
    if (step_strobe !== 1'b0) begin failures++; $display("FAIL idle strobe got=%0b exp=0", step_strobe); end
  endtask

  task automatic test_ascending();
    for (int i = 0; i < STEPS; i++) write_step(i, 1'b0, i);
    play(40, 1, 8 * 40 + 10, 1'b0, "ascending");
  endtask

  task automatic test_rest_step();
    for (int i = 0; i < STEPS; i++) write_step(i, (i == 3), (i == 3) ? 12 : 5);
    play(40, 0, 5 * 40, 1'b0, "rest_step");
  endtask

  task automatic test_legato();
    for (int i = 0; i < STEPS; i++) write_step(i, 1'b0, int'($urandom_range(15)));
    play(int'($urandom_range(4, 20)), 3, 20 * 12, 1'b0, "legato");
  endtask

  task automatic test_small_tempo();
    play(2, 1, 40, 1'b0, "tempo2");
    play(0, 2, 40, 1'b0, "tempo0");
    play(3, 0, 40, 1'b0, "tempo3");
    play(5, 1, 40, 1'b0, "tempo5");
  endtask

  task automatic test_stop_restart();
    for (int i = 0; i < STEPS; i++) write_step(i, 1'b0, 15 - i);
    play(40, 1, 5 * 40 + 17, 1'b0, "stop_mid5");
    play(40, 1, 60, 1'b0, "restart");
  endtask

  task automatic test_random_writes();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < STEPS; i++)
        write_step(i, ($urandom_range(3) == 0), int'($urandom_range(15)));
      play(int'($urandom_range(0, 30)), int'($urandom_range(3)),
           int'($urandom_range(30, 200)), 1'b1, "random");
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < STEPS; i++) write_step(i, 1'b0, 9);
    @(negedge clk);
    tempo_div = TICK_BITS'(8);
    gate_len  = 2'd3;
    run       = 1'b1;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (tone_freq_bin !== '0) begin failures++; $display("FAIL async tone got=%0d exp=0", tone_freq_bin); end
    if (hold !== 1'b0) begin failures++; $display("FAIL async hold got=%0b exp=0", hold); end
    if (step_idx !== '0) begin failures++; $display("FAIL async idx got=%0d exp=0", step_idx); end
    if (step_strobe !== 1'b0) begin failures++; $display("FAIL async strobe got=%0b exp=0", step_strobe); end
    @(negedge clk);
    run   = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < STEPS; i++) model_pat[i] = {1'b1, FREQ_BITS'(0)};
    model_tone = '0;
    play(8, 3, 40, 1'b0, "after_reset");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_ascending();
    test_rest_step();
    test_legato();
    test_small_tempo();
    test_stop_restart();
    test_random_writes();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
